serial_subtractor_16bit: RTL
============================

SERIAL_SUBTRACTOR_16BIT -- requirements
Module: serial_subtractor_16bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 x  input  16  minuend; sampled only on an accepted start.
REQ-005 y  input  16  subtrahend; sampled only on an accepted start.
REQ-006 start  input  1  request to begin x - y; single-cycle or held, level-sampled.
REQ-007 d  output  16  registered difference x - y, modulo 2^16.
REQ-008 Bout  output  1  registered unsigned borrow; 1 when x < y unsigned.
REQ-009 Ov  output  1  registered two's-complement overflow of x - y.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; d, Bout and Ov are valid and updated in this cycle.

Function
REQ-012 The block SHALL compute d = x + ~y + 1 bit-serially, one bit per clock, LSB first, using one full-adder cell and a carry flip-flop.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch x and y into internal shift registers, clear the 4-bit bit counter, set the carry flip-flop to 1, and enter RUN.
REQ-015 IDLE: start=0 SHALL leave all state unchanged.
REQ-016 RUN: each edge SHALL process bit[cnt]: sum = xs[0] ^ ~ys[0] ^ c, then update c = carry-out, shift sum into the result register, shift both operand registers right, and increment cnt.
REQ-017 RUN: the edge that processes bit 15 (cnt=15) SHALL perform all of the following:
- load the complete 16-bit result into d;
- set Bout = ~carry-out(bit 15);
- set Ov = carry-in(bit 15) XOR carry-out(bit 15);
- enter DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 Latency: start accepted at edge N SHALL produce done=1 in the cycle following edge N+16 (16 RUN cycles).
REQ-021 start asserted in RUN or DONE SHALL be ignored and SHALL NOT affect the current result. A new start is accepted only in IDLE, so the earliest re-accept is the first edge after DONE.
REQ-022 Back-to-back: start held high continuously SHALL produce one operation every 18 cycles (IDLE, 16 RUN, DONE).
REQ-023 d, Bout and Ov SHALL hold the last completed result until the next DONE. Intermediate bits SHALL never appear on d.
REQ-024 Changes on x and y after acceptance SHALL NOT affect the operation in progress.
REQ-025 Wrap-around: cnt SHALL be 4 bits and SHALL wrap to 0 only on the transition to DONE.

Reset
REQ-026 reset_n=0 SHALL immediately force, regardless of clk:
- state to IDLE;
- d=0x0000, Bout=0, Ov=0, busy=0, done=0;
- cnt=0, carry=0, and operand and result shift registers to 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the partial result SHALL be discarded.
REQ-028 After reset_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 Basic subtract: x=0x0005, y=0x0003, start pulse -> 16 busy cycles, then a done pulse with d=0x0002, Bout=0, Ov=0.
REQ-030 Unsigned borrow: x=0x0000, y=0x0001 -> d=0xFFFF, Bout=1, Ov=0.
REQ-031 Signed overflow:
- x=0x8000, y=0x0001 -> d=0x7FFF, Bout=0, Ov=1;
- x=0x7FFF, y=0xFFFF -> d=0x8000, Bout=1, Ov=1.
REQ-032 Ignored start: start with x=0x1234, y=0x0034; at RUN cycle 5, pulse start with x=0xFFFF, y=0x0001 -> a single done with d=0x1200, and the block then returns to IDLE with no second operation.
REQ-033 Reset mid-op: x=0xAAAA, y=0x5555; assert reset_n=0 at RUN cycle 8 -> all outputs 0 asynchronously and no done pulse. A following start with x=0x0010, y=0x0010 -> d=0x0000, Bout=0, Ov=0 after 16 cycles.
REQ-034 Streaming: start held high for 3 operations -> done pulses exactly 18 cycles apart, each carrying the result for the operands present at its accepting edge.

Source files
------------

// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit
//   Bit-serial 16-bit subtractor. It computes d = x + ~y + 1 one bit per clock,
//   LSB first, using a single full-adder cell and a carry flip-flop.
//   An operation is accepted only in IDLE. It then runs for 16 cycles in RUN and
//   spends one cycle in DONE, so the latency is 18 cycles from accept to accept.
//
// Ports
//   clk      clock; all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   x, y     minuend / subtrahend, sampled on an accepted start
//   start    level-sampled request; ignored outside IDLE
//   d        registered difference x - y (mod 2^16)
//   Bout     registered unsigned borrow (x < y)
//   Ov       registered two's-complement overflow
//   busy     high exactly in RUN
//   done     one-cycle pulse in DONE; d/Bout/Ov are valid in this cycle
module serial_subtractor_16bit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        start,
    output logic [15:0] d,
    output logic        Bout,
    output logic        Ov,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] xs_q, xs_d;
    logic [15:0] ys_q, ys_d;
    logic [15:0] rs_q, rs_d;
    logic [15:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        c_q, c_d;
    logic        bout_q, bout_d;
    logic        ov_q, ov_d;
    logic        yb;
    logic        sum;
    logic        cout;

    // Full-adder cell on the current LSBs, with the subtrahend bit inverted
    always_comb begin
        yb   = ~ys_q[0];
        sum  = xs_q[0] ^ yb ^ c_q;
        cout = (xs_q[0] & yb) | (c_q & (xs_q[0] ^ yb));
    end

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        rs_d    = rs_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        bout_d  = bout_q;
        ov_d    = ov_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    cnt_d   = 4'd0;
                    c_d     = 1'b1;  // the +1 of the two's-complement negation
                    state_d = StRun;
                end
            end
            StRun: begin
                rs_d  = {sum, rs_q[15:1]};
                xs_d  = {1'b0, xs_q[15:1]};
                ys_d  = {1'b0, ys_q[15:1]};
                c_d   = cout;
                cnt_d = cnt_q + 4'd1;  // wraps to 0 on the last bit
                if (cnt_q == 4'd15) begin
                    // The result register is published only when complete
                    d_d     = {sum, rs_q[15:1]};
                    bout_d  = ~cout;
                    ov_d    = c_q ^ cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            xs_q    <= 16'h0000;
            ys_q    <= 16'h0000;
            rs_q    <= 16'h0000;
            d_q     <= 16'h0000;
            cnt_q   <= 4'd0;
            c_q     <= 1'b0;
            bout_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            bout_q  <= bout_d;
            ov_q    <= ov_d;
        end
    end

    assign d    = d_q;
    assign Bout = bout_q;
    assign Ov   = ov_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule
